// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using one double-dabble step per cycle.
// Results saturate to all nines when the value does not fit in DIGITS digits.
module bin2bcd_seq #(
    parameter int DATA_W = 20,
    parameter int DIGITS = 6
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     data,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int SCR_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_bin;
    logic [SCR_W-1:0]   r_scr;
    logic               r_sticky;
    logic               r_done;
    logic [SCR_W-1:0]   r_bcd;
    logic               r_ovf;
    logic [DIGITS-1:0]  r_blank;

    logic               w_load;
    logic               w_step;
    logic               w_fin;
    logic               w_last;
    logic [SCR_W-1:0]   w_corr;
    logic [SCR_W-1:0]   w_nines;
    logic [DIGITS-1:0]  w_blank;

    assign w_last = (r_cnt == CNT_W'(DATA_W - 1));

    always_comb begin
        w_corr  = '0;
        w_nines = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scr[4*i +: 4] > 4'd4)
                w_corr[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
            else
                w_corr[4*i +: 4] = r_scr[4*i +: 4];
            w_nines[4*i +: 4] = 4'h9;
        end
    end

    // Digit i is blankable only if it and every digit above it are zero.
    always_comb begin : blank_p
        logic v_run;
        v_run   = 1'b1;
        w_blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_run      = v_run & (r_scr[4*i +: 4] == 4'd0);
            w_blank[i] = v_run;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_fin       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_step = 1'b1;
                if (w_last)
                    w_state_nxt = DONE;
            end
            DONE: begin
                w_fin       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt    <= '0;
            r_bin    <= '0;
            r_scr    <= '0;
            r_sticky <= 1'b0;
        end else if (w_load) begin
            r_cnt    <= '0;
            r_bin    <= data;
            r_scr    <= '0;
            r_sticky <= 1'b0;
        end else if (w_step) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_bin    <= {r_bin[DATA_W-2:0], 1'b0};
            r_scr    <= {w_corr[SCR_W-2:0], r_bin[DATA_W-1]};
            r_sticky <= r_sticky | w_corr[SCR_W-1];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_done  <= 1'b0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_blank <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            r_done <= w_fin;
            if (w_fin) begin
                r_bcd   <= r_sticky ? w_nines : r_scr;
                r_ovf   <= r_sticky;
                r_blank <= r_sticky ? '0 : w_blank;
            end
        end
    end

    assign busy  = (r_state != IDLE);
    assign done  = r_done;
    assign bcd   = r_bcd;
    assign ovf   = r_ovf;
    assign blank = r_blank;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 20: binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 6: number of BCD output digits, legal range 2..10.
REQ-003 SHALL have port sys_clk, input, 1: clock, all state updates on the rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: conversion request, sampled only in IDLE.
REQ-006 SHALL have port data, input, DATA_W: unsigned binary operand, sampled with start.
REQ-007 SHALL have port busy, output, 1: high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1: single-cycle pulse when the results update.
REQ-009 SHALL have port bcd, output, 4*DIGITS: packed result, digit 0 (units) in bits [3:0], digit i in bits [4i+3:4i].
REQ-010 SHALL have port ovf, output, 1: the last result exceeded 10^DIGITS-1.
REQ-011 SHALL have port blank, output, DIGITS: leading-zero mask, bit i set when digit i is a suppressible leading zero.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL, in IDLE with start=1, capture data into the shift register, clear the BCD scratch and the sticky overflow flag, clear the iteration counter, and go to SHIFT.
REQ-014 SHALL, in IDLE with start=0, hold all state and outputs.
REQ-015 SHALL, in SHIFT, perform exactly one double-dabble iteration per cycle: add 3 to every scratch digit greater than 4, then shift the {scratch, binary} concatenation left by 1, all in the same cycle.
REQ-016 SHALL, on each SHIFT iteration, OR the bit shifted out of the top scratch digit (after correction) into the sticky overflow flag.
REQ-017 SHALL leave SHIFT for DONE after exactly DATA_W iterations; the counter SHALL be ceil(log2(DATA_W+1)) bits wide.
REQ-018 SHALL, in DONE, register bcd, ovf and blank, pulse done=1 for the following cycle, and return to IDLE.
REQ-019 SHALL make latency fixed: start sampled at edge N gives done=1 in the cycle after edge N+DATA_W+1, independent of the data value.
REQ-020 SHALL drive busy=1 from edge N up to edge N+DATA_W+1; busy and done SHALL never both be 1.
REQ-021 SHALL ignore start while busy=1: no restart and no queuing.
REQ-022 SHALL accept start in the cycle done=1 (FSM already in IDLE), giving back-to-back conversions every DATA_W+2 cycles.
REQ-023 SHALL, on overflow, saturate bcd to all digits 9, set ovf=1 and set blank to all zeros.
REQ-024 SHALL, without overflow, set blank bit i (i>=1) when digit i and all higher digits are 0; blank bit 0 SHALL always be 0.
REQ-025 SHALL hold bcd, ovf and blank stable between done pulses, including during a subsequent conversion.
REQ-026 SHALL keep the scratch register 4*DIGITS bits wide; no intermediate value SHALL be truncated except via the overflow path of REQ-016.

Reset
REQ-027 SHALL, on sys_rst_n=0, asynchronously force state=IDLE, counter=0, shift/scratch/sticky registers=0, busy=0, done=0, bcd=0, ovf=0 and blank={DIGITS-1 ones, 0}.
REQ-028 SHALL, on reset asserted mid-conversion, abort the conversion, produce no done pulse, and ignore start until the first edge after deassertion.

Verification (DATA_W=20, DIGITS=6)
REQ-029 SHALL cover: data=123456 with start at edge N -> done pulse after edge N+21; bcd=0x123456, ovf=0, blank=000000.
REQ-030 SHALL cover: data=0 -> bcd=0x000000, ovf=0, blank=111110; data=7 -> bcd=0x000007, blank=111110.
REQ-031 SHALL cover: data=999999 -> bcd=0x999999, ovf=0; data=1048575 -> bcd=0x999999, ovf=1, blank=000000.
REQ-032 SHALL cover: start asserted with data=5 at edge N+5 during a conversion of 42 -> single done with bcd=0x000042, no second done.
REQ-033 SHALL cover: start held high continuously with data=1000 -> done pulses every 22 cycles, each with bcd=0x001000, blank=110000.
REQ-034 SHALL cover: reset asserted at iteration 10 of a conversion of 54321 -> busy=0, bcd=0 immediately, no done; next conversion of 54321 gives bcd=0x054321, blank=100000.
